// File: rtl/base_complement_stream.sv
// Streaming nucleotide complementer. Takes LANES ASCII bases per beat and
// either complements each beat in order (mode 0) or buffers the sequence and
// emits its reverse complement (mode 1). Counts invalid bases and flags
// mode-1 sequences longer than the buffer.
module base_complement_stream #(
    parameter int LANES   = 4,
    parameter int DEPTH   = 64,
    parameter int COUNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:LANES*8-1]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:LANES*8-1]   out_data,
    output logic                 out_last,
    output logic [COUNT_W-1:0]   invalid_count,
    output logic                 overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = LANES * 8;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PASS, FILL, DRAIN} state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            ready_en_reg;
    logic            pass_done_reg;
    logic            drain_more_reg;
    logic [AW:0]     wptr_reg;
    logic [AW-1:0]   rptr_reg;
    logic [0:DW-1]   mem [DEPTH];

    logic [0:DW-1]   comp_data;
    logic [LANES-1:0] lane_bad;
    logic [0:DW-1]   rd_word;
    logic [0:DW-1]   rev_word;
    logic [COUNT_W:0] bad_sum;
    logic [COUNT_W:0] count_sum;
    logic            in_fire;
    logic            out_fire;
    logic            first_beat;
    logic            take_pass;
    logic            take_fill;
    logic [AW:0]     fill_cnt;
    logic            wr_en;
    logic [AW:0]     wptr_after;
    logic            drain_load;

    // Complement one ASCII base; bit 8 flags a byte that is not a known base.
    function automatic logic [8:0] comp_base(input logic [7:0] b);
        case (b)
            8'h41:   comp_base = {1'b0, 8'h54};  // A -> T
            8'h54:   comp_base = {1'b0, 8'h41};  // T -> A
            8'h43:   comp_base = {1'b0, 8'h47};  // C -> G
            8'h47:   comp_base = {1'b0, 8'h43};  // G -> C
            8'h61:   comp_base = {1'b0, 8'h74};  // a -> t
            8'h74:   comp_base = {1'b0, 8'h61};  // t -> a
            8'h63:   comp_base = {1'b0, 8'h67};  // c -> g
            8'h67:   comp_base = {1'b0, 8'h63};  // g -> c
            8'h4E:   comp_base = {1'b0, 8'h4E};  // N
            8'h6E:   comp_base = {1'b0, 8'h6E};  // n
            default: comp_base = {1'b1, 8'h4E};  // anything else becomes N
        endcase
    endfunction

    // Buffered words are stored already complemented, so the drain side only
    // has to swap lane order.
    assign rd_word = mem[rptr_reg];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign {lane_bad[gi], comp_data[gi*8 +: 8]} = comp_base(in_data[gi*8 +: 8]);
        assign rev_word[gi*8 +: 8] = rd_word[(LANES-1-gi)*8 +: 8];
    end

    // Number of invalid lanes in the current input beat.
    always_comb begin
        bad_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            bad_sum = bad_sum + (COUNT_W+1)'(lane_bad[i]);
        end
    end

    assign count_sum = {1'b0, invalid_count} + bad_sum;

    // IDLE/PASS share the output register with the complement path, so they
    // can only take a beat when that register is free or emptying.
    assign in_ready = ready_en_reg &&
                      (((state_reg == IDLE || state_reg == PASS) && (!out_valid || out_ready)) ||
                       (state_reg == FILL));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // A first beat arrives in IDLE, or in PASS once the previous sequence's
    // last beat has been accepted (back-to-back sequences).
    assign first_beat = (state_reg == IDLE) || (state_reg == PASS && pass_done_reg);
    assign take_pass  = in_fire && ((first_beat && !mode) || (state_reg == PASS && !pass_done_reg));
    assign take_fill  = in_fire && ((first_beat && mode) || (state_reg == FILL));

    assign fill_cnt   = first_beat ? '0 : wptr_reg;
    assign wr_en      = take_fill && (fill_cnt != FULL);
    assign wptr_after = fill_cnt + (AW+1)'(wr_en);
    assign drain_load = (state_reg == DRAIN) && drain_more_reg && (!out_valid || out_ready);

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (take_pass)      state_next = PASS;
                else if (take_fill) state_next = in_last ? DRAIN : FILL;
            end
            PASS: begin
                if (take_fill)                 state_next = in_last ? DRAIN : FILL;
                else if (take_pass)            state_next = PASS;
                else if (out_fire && out_last) state_next = IDLE;
            end
            FILL: begin
                if (take_fill && in_last) state_next = DRAIN;
            end
            DRAIN: begin
                if (out_fire && out_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reverse-complement buffer write port; contents need no reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[fill_cnt[AW-1:0]] <= comp_data;
        end
    end

    // Pointers, output register, flags and the invalid-base counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_reg   <= 1'b0;
            pass_done_reg  <= 1'b0;
            drain_more_reg <= 1'b0;
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_data       <= {LANES{8'h02}};
            invalid_count  <= '0;
            overflow       <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;

            if (take_fill) begin
                wptr_reg <= wptr_after;
            end
            if (take_fill && in_last) begin
                rptr_reg       <= AW'(wptr_after - (AW+1)'(1));
                drain_more_reg <= 1'b1;
            end

            if (take_pass) begin
                pass_done_reg <= in_last;
            end

            if (in_fire && first_beat) begin
                overflow <= 1'b0;
            end else if (take_fill && !wr_en) begin
                overflow <= 1'b1;
            end

            if (in_fire) begin
                invalid_count <= count_sum[COUNT_W] ? '1 : count_sum[COUNT_W-1:0];
            end

            if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (take_pass) begin
                out_data  <= comp_data;
                out_valid <= 1'b1;
                out_last  <= in_last;
            end else if (drain_load) begin
                out_data  <= rev_word;
                out_valid <= 1'b1;
                out_last  <= (rptr_reg == '0);
                if (rptr_reg == '0) begin
                    drain_more_reg <= 1'b0;
                end else begin
                    rptr_reg <= rptr_reg - AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_base_complement_stream.sv
// Directed bench for base_complement_stream: table of mode-0 beats plus
// hand-written mode-1, overflow, backpressure, saturation and reset cases.
`timescale 1ns/1ps
module tb_base_complement_stream;
    localparam int LANES   = 4;
    localparam int DEPTH   = 4;
    localparam int COUNT_W = 6;
    localparam int DW      = LANES * 8;
    localparam int CMAX    = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               mode = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [0:DW-1]      in_data = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [0:DW-1]      out_data;
    logic               out_last;
    logic [COUNT_W-1:0] invalid_count;
    logic               overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    typedef struct {
        logic [0:DW-1] din;
        logic          last;
        logic [0:DW-1] dout;
        int            bad;
    } vec_t;

    vec_t          vecs [7];
    logic [0:DW-1] ovf_in  [6];
    logic [0:DW-1] ovf_exp [4];
    logic [0:DW-1] s_in    [4];
    logic [0:DW-1] s_exp   [4];

    always #5 clk = ~clk;

    base_complement_stream #(
        .LANES   (LANES),
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clock         (clk),
        .reset_n       (rst_n),
        .mode          (mode),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .invalid_count (invalid_count),
        .overflow      (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check({name, " out_valid"}, 64'(out_valid), 64'd1);
    endtask

    // Random out_ready; every transfer is compared in order and stalled beats
    // must hold their data.
    task automatic run_stream(input string name, input logic m, input int n_in, input int n_out);
        int ip;
        int op;
        int cyc;
        logic held;
        logic [0:DW-1] held_data;
        logic in_acc;
        logic out_acc;
        ip = 0; op = 0; cyc = 0; held = 1'b0; held_data = '0;
        mode = m; in_valid = 1'b1; in_data = s_in[0]; in_last = (n_in == 1);
        out_ready = ($urandom_range(0, 1) == 1);
        while (op < n_out && cyc < 400) begin
            @(negedge clk);
            in_acc  = in_valid && in_ready;
            out_acc = out_valid && out_ready;
            if (held) begin
                check({name, " stall valid"}, 64'(out_valid), 64'd1);
                check({name, " stall data"}, 64'(out_data), 64'(held_data));
            end
            if (out_acc) begin
                check({name, " data"}, 64'(out_data), 64'(s_exp[op]));
                check({name, " last"}, 64'(out_last), 64'(op == n_out - 1));
                $display("%s: out beat %0d = %s last=%0b", name, op, out_data, out_last);
                op++;
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            @(posedge clk);
            #1;
            if (in_acc) begin
                ip++;
                if (ip < n_in) begin
                    in_data = s_in[ip];
                    in_last = (ip == n_in - 1);
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 1) == 1);
            cyc++;
        end
        check({name, " beats out"}, 64'(op), 64'(n_out));
        check({name, " beats in"}, 64'(ip), 64'(n_in));
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"ACGT", 1'b0, "TGCA", 0};
        vecs[1] = '{"tgca", 1'b1, "acgt", 0};
        vecs[2] = '{"AXN?", 1'b1, "TNNN", 2};
        vecs[3] = '{"nNaC", 1'b1, "nNtG", 0};
        vecs[4] = '{"GgTt", 1'b0, "CcAa", 0};
        vecs[5] = '{"1234", 1'b1, "NNNN", 4};
        vecs[6] = '{"cCgG", 1'b1, "gGcC", 0};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data", 64'(out_data), 64'h02020202);
        check("rst out_last", 64'(out_last), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst count", 64'(invalid_count), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        #1;
        check("release in_ready before clock", 64'(in_ready), 64'd0);
        tick();
        check("release in_ready after clock", 64'(in_ready), 64'd1);

        // ---- mode 0 table, back-to-back beats ----
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            mode = 1'b0; in_valid = 1'b1; in_data = vecs[i].din; in_last = vecs[i].last;
            check("tbl in_ready", 64'(in_ready), 64'd1);
            tick();
            exp_cnt = sat(exp_cnt + vecs[i].bad);
            check("tbl out_valid", 64'(out_valid), 64'd1);
            check("tbl out_data", 64'(out_data), 64'(vecs[i].dout));
            check("tbl out_last", 64'(out_last), 64'(vecs[i].last));
            check("tbl count", 64'(invalid_count), 64'(exp_cnt));
            $display("tbl %0d: in=%s out=%s last=%0b count=%0d", i, vecs[i].din, out_data, out_last, invalid_count);
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        tick();
        check("idle out_valid", 64'(out_valid), 64'd0);

        // ---- mode 1 two-beat reverse complement ----
        mode = 1'b1; in_valid = 1'b1; in_data = "AACC"; in_last = 1'b0;
        tick();
        in_data = "GGTT"; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("m1 valid after 1 cycle", 64'(out_valid), 64'd0);
        check("m1 in_ready drain", 64'(in_ready), 64'd0);
        tick();
        check("m1 valid after 2 cycles", 64'(out_valid), 64'd1);
        check("m1 beat0 data", 64'(out_data), 64'("AACC"));
        check("m1 beat0 last", 64'(out_last), 64'd0);
        check("m1 in_ready drain2", 64'(in_ready), 64'd0);
        $display("m1: out beat 0 = %s", out_data);
        tick();
        check("m1 beat1 data", 64'(out_data), 64'("GGTT"));
        check("m1 beat1 last", 64'(out_last), 64'd1);
        $display("m1: out beat 1 = %s", out_data);
        tick();
        check("m1 done valid", 64'(out_valid), 64'd0);
        check("m1 done in_ready", 64'(in_ready), 64'd1);

        // ---- overflow: 6 beats into a 4-deep buffer ----
        ovf_in[0] = "AAAC"; ovf_in[1] = "CCCG"; ovf_in[2] = "GGGT";
        ovf_in[3] = "TTTA"; ovf_in[4] = "acgt"; ovf_in[5] = "gggg";
        ovf_exp[0] = "TAAA"; ovf_exp[1] = "ACCC"; ovf_exp[2] = "CGGG"; ovf_exp[3] = "GTTT";
        for (int i = 0; i < 6; i++) begin
            mode = 1'b1; in_valid = 1'b1; in_data = ovf_in[i]; in_last = (i == 5);
            check("ovf in_ready", 64'(in_ready), 64'd1);
            tick();
            check("ovf flag", 64'(overflow), 64'(i >= 4));
        end
        in_valid = 1'b0; in_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ovf out_valid", 64'(out_valid), 64'd1);
            check("ovf out_data", 64'(out_data), 64'(ovf_exp[k]));
            check("ovf out_last", 64'(out_last), 64'(k == 3));
            $display("ovf: out beat %0d = %s", k, out_data);
        end
        tick();
        check("ovf held after drain", 64'(overflow), 64'd1);
        check("ovf drained valid", 64'(out_valid), 64'd0);
        mode = 1'b0; in_valid = 1'b1; in_data = "ACGT"; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("ovf cleared", 64'(overflow), 64'd0);
        check("ovf next seq data", 64'(out_data), 64'("TGCA"));
        tick();

        // ---- backpressure, both modes ----
        s_in[0] = "ACGT"; s_in[1] = "GATT"; s_in[2] = "ccaa"; s_in[3] = "TNAG";
        s_exp[0] = "TGCA"; s_exp[1] = "CTAA"; s_exp[2] = "ggtt"; s_exp[3] = "ANTC";
        run_stream("bp0", 1'b0, 4, 4);
        s_in[0] = "ACGA"; s_in[1] = "TTGC"; s_in[2] = "AGNn";
        s_exp[0] = "nNCT"; s_exp[1] = "GCAA"; s_exp[2] = "TCGT";
        run_stream("bp1", 1'b1, 3, 3);

        // ---- invalid_count saturation ----
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mode = 1'b0; in_valid = 1'b1; in_data = "?X!#"; in_last = 1'b1;
            tick();
            exp_cnt = sat(exp_cnt + 4);
            check("sat count", 64'(invalid_count), 64'(exp_cnt));
            check("sat data", 64'(out_data), 64'("NNNN"));
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("sat final", 64'(invalid_count), 64'(CMAX));
        tick();
        tick();

        // ---- reset in the middle of DRAIN ----
        out_ready = 1'b0;
        mode = 1'b1; in_valid = 1'b1; in_data = "AACC"; in_last = 1'b0;
        tick();
        in_data = "GGTT"; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        wait_valid("mid-drain");
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst out_data", 64'(out_data), 64'h02020202);
        check("midrst out_last", 64'(out_last), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd0);
        check("midrst count", 64'(invalid_count), 64'd0);
        check("midrst overflow", 64'(overflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst ready pre-clock", 64'(in_ready), 64'd0);
        tick();
        check("midrst ready post-clock", 64'(in_ready), 64'd1);
        out_ready = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = "ACGT"; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("post-rst valid", 64'(out_valid), 64'd1);
        check("post-rst data", 64'(out_data), 64'("TGCA"));
        check("post-rst last", 64'(out_last), 64'd1);
        $display("post-rst: out beat = %s", out_data);
        tick();
        check("post-rst idle", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
